// File: rtl/exe_divider_pkg.sv
// Shared CPU definitions used by the EXE-stage divider: operand width,
// divide opcode encodings and the divider FSM state type.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] DIV_W  = 2'b00;
    localparam logic [1:0] MOD_W  = 2'b01;
    localparam logic [1:0] DIV_WU = 2'b10;
    localparam logic [1:0] MOD_WU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_SIGN,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/exe_divider_if.sv
// Bundle between the EXE stage control and the iterative divider.
// The master is the EXE stage, the slave is the divider itself.
interface exe_divider_if #(parameter int W = 32);

    logic         flush;
    logic         div_valid;
    logic [1:0]   div_op;
    logic [W-1:0] div_src1;
    logic [W-1:0] div_src2;
    logic         ms_allowin;
    logic         div_busy;
    logic         div_done;
    logic [W-1:0] div_result;

    modport master (
        output flush, div_valid, div_op, div_src1, div_src2, ms_allowin,
        input  div_busy, div_done, div_result
    );

    modport slave (
        input  flush, div_valid, div_op, div_src1, div_src2, ms_allowin,
        output div_busy, div_done, div_result
    );

endinterface

// File: rtl/exe_divider_step.sv
// One restoring-division step: shift {R,Q} left by one, try to subtract the
// divisor from R and shift the success bit into Q.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] r_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] r_o,
    output logic [W-1:0] q_o
);

    logic [W:0] r_sh;
    logic [W:0] trial;

    // R < d holds between steps, so the shifted remainder fits in W+1 bits and
    // the top bit of the trial difference is a clean borrow flag.
    assign r_sh  = {r_i, q_i[W-1]};
    assign trial = r_sh - {1'b0, d_i};

    assign r_o = trial[W] ? r_sh[W-1:0] : trial[W-1:0];
    assign q_o = {q_i[W-2:0], ~trial[W]};

endmodule

// File: rtl/exe_divider.sv
// Iterative 32-bit signed/unsigned divider for the EXE stage: one quotient
// bit per cycle on operand magnitudes, then a single sign-fix cycle.
module exe_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          resetn,
    exe_divider_if.slave dif
);

    import cpu_pkg::*;

    div_state_t        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              sq_q, sq_d;
    logic              sr_q, sr_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   src1_q, src1_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic [XLEN-1:0]   q_q, q_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;

    logic              is_signed, s1, s2;
    logic [XLEN-1:0]   abs1, abs2, quo, rem, step_r, step_q;

    assign is_signed = (dif.div_op == DIV_W) || (dif.div_op == MOD_W);
    assign s1        = is_signed & dif.div_src1[XLEN-1];
    assign s2        = is_signed & dif.div_src2[XLEN-1];
    assign abs1      = s1 ? -dif.div_src1 : dif.div_src1;
    assign abs2      = s2 ? -dif.div_src2 : dif.div_src2;

    // Divide by zero bypasses the sign fix: all-ones quotient, raw dividend.
    assign quo = zero_q ? '1     : (sq_q ? -q_q : q_q);
    assign rem = zero_q ? src1_q : (sr_q ? -r_q : r_q);

    div_step #(.W(XLEN)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (divisor_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sq_d      = sq_q;
        sr_d      = sr_q;
        zero_d    = zero_q;
        src1_d    = src1_q;
        divisor_d = divisor_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        if (dif.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dif.div_valid) begin
                        op_d      = dif.div_op;
                        sq_d      = s1 ^ s2;
                        sr_d      = s1;
                        zero_d    = (dif.div_src2 == '0);
                        src1_d    = dif.div_src1;
                        divisor_d = abs2;
                        r_d       = '0;
                        q_d       = abs1;
                        cnt_d     = '0;
                        state_d   = S_DIV;
                    end
                end
                S_DIV: begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = S_SIGN;
                    end
                end
                S_SIGN: begin
                    result_d = op_q[0] ? rem : quo;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (dif.ms_allowin) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            zero_q    <= 1'b0;
            src1_q    <= '0;
            divisor_q <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            zero_q    <= zero_d;
            src1_q    <= src1_d;
            divisor_q <= divisor_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
        end
    end

    assign dif.div_busy   = busy_q;
    assign dif.div_done   = (state_q == S_DONE);
    assign dif.div_result = result_q;

endmodule

// File: tb/tb_exe_divider.sv
// Self-checking bench for exe_divider: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_exe_divider;

    localparam logic [1:0] OP_DIV_W  = 2'b00;
    localparam logic [1:0] OP_MOD_W  = 2'b01;
    localparam logic [1:0] OP_DIV_WU = 2'b10;
    localparam logic [1:0] OP_MOD_WU = 2'b11;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    exe_divider_if #(.W(32)) dif ();

    exe_divider #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected result from the architectural definition of the operations.
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sres;
        if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
        if (op[1]) return op[0] ? (a % b) : (a / b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sres = op[0] ? (sa % sb) : (sa / sb);
        return sres[31:0];
    endfunction

    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        dif.div_valid = valid;
        dif.div_op    = op;
        dif.div_src1  = a;
        dif.div_src2  = b;
    endtask

    // Launch from IDLE; lat is the cycle index (launch cycle = 0) where done is first seen.
    task automatic doDivide(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit dropEarly, output int lat, output logic [31:0] res);
        applyStimulus(1'b1, op, a, b);
        @(posedge clk); #1;
        lat = 1;
        checkOutput("busy_after_launch", {31'd0, dif.div_busy}, 32'd1);
        if (dropEarly) dif.div_valid = 1'b0;
        while (!dif.div_done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        dif.div_valid = 1'b0;
        res = dif.div_result;
    endtask

    task automatic finishDivide(input int hold, input logic [31:0] exp);
        dif.ms_allowin = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_done", {31'd0, dif.div_done}, 32'd1);
            checkOutput("hold_result", dif.div_result, exp);
        end
        dif.ms_allowin = 1'b1;
        @(posedge clk); #1;
        dif.ms_allowin = 1'b0;
        checkOutput("done_drop", {31'd0, dif.div_done}, 32'd0);
        checkOutput("busy_drop", {31'd0, dif.div_busy}, 32'd0);
    endtask

    task automatic runCase(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int hold);
        int          lat;
        logic [31:0] res;
        doDivide(op, a, b, 1'b0, lat, res);
        checkOutput({tag, "_lat"}, 32'(lat), 32'd34);
        checkOutput(tag, res, exp);
        finishDivide(hold, exp);
    endtask

    initial begin
        int          lat;
        logic [31:0] res, a, b;
        logic [1:0]  op;

        checks         = 0;
        failures       = 0;
        resetn         = 1'b0;
        dif.flush      = 1'b0;
        dif.ms_allowin = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, dif.div_busy}, 32'd0);
        checkOutput("reset_done", {31'd0, dif.div_done}, 32'd0);
        checkOutput("reset_result", dif.div_result, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        runCase("div_w_100_7", OP_DIV_W, 32'd100, 32'd7, 32'd14, 3);
        runCase("mod_w_m7_2", OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        runCase("div_w_m7_2", OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        runCase("div_wu_max_2", OP_DIV_WU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0);
        runCase("mod_wu_max_2", OP_MOD_WU, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
        runCase("div_w_ovf", OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        runCase("mod_w_ovf", OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        runCase("div_w_by0", OP_DIV_W, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        runCase("mod_w_by0", OP_MOD_W, 32'd5, 32'd0, 32'd5, 0);
        runCase("mod_w_neg_by0", OP_MOD_W, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 0);
        runCase("div_wu_big", OP_DIV_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0);
        runCase("mod_wu_big", OP_MOD_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0);

        // Flush at cycle 10 of a divide, then relaunch at cycle 11.
        applyStimulus(1'b1, OP_DIV_W, 32'd1000, 32'd3);
        @(posedge clk); #1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("flush_busy_before", {31'd0, dif.div_busy}, 32'd1);
        dif.flush     = 1'b1;
        dif.div_valid = 1'b0;
        @(posedge clk); #1;
        dif.flush = 1'b0;
        checkOutput("flush_busy", {31'd0, dif.div_busy}, 32'd0);
        checkOutput("flush_done", {31'd0, dif.div_done}, 32'd0);
        doDivide(OP_DIV_WU, 32'd9, 32'd3, 1'b0, lat, res);
        checkOutput("post_flush_cycle", 32'(11 + lat), 32'd45);
        checkOutput("post_flush_result", res, 32'd3);
        finishDivide(0, 32'd3);

        // Synchronous reset in the middle of the iteration.
        applyStimulus(1'b1, OP_DIV_W, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #1;
        resetn        = 1'b0;
        dif.div_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_busy", {31'd0, dif.div_busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, dif.div_done}, 32'd0);
        checkOutput("midreset_result", dif.div_result, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_idle", {31'd0, dif.div_busy}, 32'd0);

        // Flush wins over a simultaneous valid in IDLE.
        applyStimulus(1'b1, OP_DIV_W, 32'd50, 32'd5);
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush     = 1'b0;
        dif.div_valid = 1'b0;
        checkOutput("flush_vs_valid_busy", {31'd0, dif.div_busy}, 32'd0);
        @(posedge clk); #1;
        checkOutput("flush_vs_valid_idle", {31'd0, dif.div_busy}, 32'd0);

        // Dropping div_valid mid-operation must not abort it.
        doDivide(OP_MOD_W, 32'd77, 32'hFFFF_FFF6, 1'b1, lat, res);
        checkOutput("drop_valid_lat", 32'(lat), 32'd34);
        checkOutput("drop_valid_result", res, 32'd7);
        finishDivide(1, 32'd7);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            runCase("random", op, a, b, refModel(op, a, b), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
